// File: rtl/uartprobe_axi_arbiter_if.sv
// Single-beat AXI4-lite style master bus shared by the probe requesters.
// master: arbiter side, slave: fabric side.
interface uartprobe_axi_arbiter_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic [2:0]  arsize;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic [2:0]  awsize;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arvalid, arsize,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready,
        output awaddr, awvalid, awsize,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  araddr, arvalid, arsize,
        output arready,
        output rdata, rresp, rvalid,
        input  rready,
        input  awaddr, awvalid, awsize,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/uartprobe_axi_arbiter.sv
// Two-requester round-robin arbiter and single-beat sequencer
// for the UART probe's AXI master port.
module uartprobe_axi_arbiter #(
    parameter bit         PRIORITY_INIT = 1'b0,
    parameter logic [2:0] AXI_SIZE      = 3'b010
) (
    input  logic        clk,
    input  logic        m_aresetn,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_write,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    input  logic [3:0]  req0_wstrb,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_rdata,
    output logic [1:0]  rsp0_resp,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_write,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    input  logic [3:0]  req1_wstrb,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_rdata,
    output logic [1:0]  rsp1_resp,
    output logic        busy,
    output logic        last_grant,
    uartprobe_axi_arbiter_if.master m_axi
);

    typedef enum logic [2:0] {
        S_IDLE, S_AR, S_R, S_AWW, S_B, S_RSP
    } state_t;

    state_t      state, state_d;
    logic        grant;
    logic        accept;
    logic        sel_write;
    logic        aw_hs, w_hs;
    logic        aw_done, w_done;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  wstrb_q;
    logic [1:0]  resp_q;
    logic        owner_q;

    // Under contention the requester not served last wins.
    always_comb begin
        grant = 1'b0;
        unique case (1'b1)
            (req0_valid && req1_valid): grant = ~last_grant;
            (req1_valid && !req0_valid): grant = 1'b1;
            default: grant = 1'b0;
        endcase
    end

    assign accept     = (state == S_IDLE) && (req0_valid || req1_valid);
    assign req0_ready = accept && !grant;
    assign req1_ready = accept && grant;
    assign sel_write  = grant ? req1_write : req0_write;
    assign aw_hs      = !aw_done && m_axi.awready;
    assign w_hs       = !w_done && m_axi.wready;

    always_ff @(posedge clk or negedge m_aresetn) begin
        if (!m_aresetn) state <= S_IDLE;
        else            state <= state_d;
    end

    always_comb begin
        state_d       = state;
        m_axi.arvalid = 1'b0;
        m_axi.rready  = 1'b0;
        m_axi.awvalid = 1'b0;
        m_axi.wvalid  = 1'b0;
        m_axi.bready  = 1'b0;
        rsp0_valid    = 1'b0;
        rsp1_valid    = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) state_d = sel_write ? S_AWW : S_AR;
            end
            S_AR: begin
                m_axi.arvalid = 1'b1;
                if (m_axi.arready) state_d = S_R;
            end
            S_R: begin
                m_axi.rready = 1'b1;
                if (m_axi.rvalid) state_d = S_RSP;
            end
            S_AWW: begin
                m_axi.awvalid = !aw_done;
                m_axi.wvalid  = !w_done;
                if ((aw_done || aw_hs) && (w_done || w_hs))
                    state_d = S_B;
            end
            S_B: begin
                m_axi.bready = 1'b1;
                if (m_axi.bvalid) state_d = S_RSP;
            end
            S_RSP: begin
                rsp0_valid = !owner_q;
                rsp1_valid = owner_q;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge m_aresetn) begin
        if (!m_aresetn) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            owner_q    <= 1'b0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            rdata_q    <= '0;
            resp_q     <= '0;
            last_grant <= ~PRIORITY_INIT;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    addr_q  <= grant ? req1_addr : req0_addr;
                    wdata_q <= grant ? req1_wdata : req0_wdata;
                    wstrb_q <= grant ? req1_wstrb : req0_wstrb;
                    owner_q <= grant;
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                end
                S_R: if (m_axi.rvalid) begin
                    rdata_q <= m_axi.rdata;
                    resp_q  <= m_axi.rresp;
                end
                S_AWW: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs)  w_done  <= 1'b1;
                end
                S_B: if (m_axi.bvalid) begin
                    rdata_q <= '0;
                    resp_q  <= m_axi.bresp;
                end
                S_RSP: last_grant <= owner_q;
                default: ;
            endcase
        end
    end

    assign busy         = (state != S_IDLE);
    assign m_axi.araddr = addr_q;
    assign m_axi.arsize = AXI_SIZE;
    assign m_axi.awaddr = addr_q;
    assign m_axi.awsize = AXI_SIZE;
    assign m_axi.wdata  = wdata_q;
    assign m_axi.wstrb  = wstrb_q;
    assign rsp0_rdata   = rdata_q;
    assign rsp1_rdata   = rdata_q;
    assign rsp0_resp    = resp_q;
    assign rsp1_resp    = resp_q;

endmodule

// File: tb/tb_uartprobe_axi_arbiter.sv
// Directed bench for uartprobe_axi_arbiter with a delay-programmable
// AXI slave model driven just after each rising edge.
module tb_uartprobe_axi_arbiter;

    logic        clk;
    logic        m_aresetn;
    logic        req0_valid, req0_ready, req0_write;
    logic [31:0] req0_addr, req0_wdata;
    logic [3:0]  req0_wstrb;
    logic        rsp0_valid;
    logic [31:0] rsp0_rdata;
    logic [1:0]  rsp0_resp;
    logic        req1_valid, req1_ready, req1_write;
    logic [31:0] req1_addr, req1_wdata;
    logic [3:0]  req1_wstrb;
    logic        rsp1_valid;
    logic [31:0] rsp1_rdata;
    logic [1:0]  rsp1_resp;
    logic        busy, last_grant;

    uartprobe_axi_arbiter_if bus ();

    uartprobe_axi_arbiter #(
        .PRIORITY_INIT(1'b0),
        .AXI_SIZE(3'b010)
    ) dut (
        .clk(clk), .m_aresetn(m_aresetn),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_wstrb(req0_wstrb),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .rsp0_resp(rsp0_resp),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_wstrb(req1_wstrb),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .rsp1_resp(rsp1_resp),
        .busy(busy), .last_grant(last_grant),
        .m_axi(bus)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int rsp0_cnt = 0;
    int rsp1_cnt = 0;
    int ar_dly, r_dly, aw_dly, w_dly, b_dly;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp, s_bresp;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rsp0_valid === 1'b1) rsp0_cnt <= rsp0_cnt + 1;
        if (rsp1_valid === 1'b1) rsp1_cnt <= rsp1_cnt + 1;
    end

    // Slave: each ready/valid rises after N cycles of the opposite side waiting.
    initial begin
        int ar_c, r_c, aw_c, w_c, b_c;
        ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
        bus.arready = 0; bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0;
        bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.arvalid === 1'b1) begin
                bus.arready = (ar_c >= ar_dly); ar_c++;
            end else begin
                bus.arready = 0; ar_c = 0;
            end
            if (bus.rready === 1'b1) begin
                bus.rvalid = (r_c >= r_dly); r_c++;
            end else begin
                bus.rvalid = 0; r_c = 0;
            end
            bus.rdata = bus.rvalid ? s_rdata : 32'h0;
            bus.rresp = bus.rvalid ? s_rresp : 2'b00;
            if (bus.awvalid === 1'b1) begin
                bus.awready = (aw_c >= aw_dly); aw_c++;
            end else begin
                bus.awready = 0; aw_c = 0;
            end
            if (bus.wvalid === 1'b1) begin
                bus.wready = (w_c >= w_dly); w_c++;
            end else begin
                bus.wready = 0; w_c = 0;
            end
            if (bus.bready === 1'b1) begin
                bus.bvalid = (b_c >= b_dly); b_c++;
            end else begin
                bus.bvalid = 0; b_c = 0;
            end
            bus.bresp = bus.bvalid ? s_bresp : 2'b00;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic mid;
        @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (3) tick;
        mid;
        n_chk++;
        if ({bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_valids got %b exp 00000",
                {bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready});
        end
        n_chk++;
        if ({busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got %b exp 00000",
                {busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid});
        end
        n_chk++;
        if (last_grant !== 1'b1) begin
            n_fail++; $display("FAIL reset_last_grant got %b exp 1", last_grant);
        end
        n_chk++;
        if ({bus.araddr, bus.wdata, rsp0_rdata} !== 96'h0) begin
            n_fail++; $display("FAIL reset_data got %h exp 0", {bus.araddr, bus.wdata, rsp0_rdata});
        end
        n_chk++;
        if (bus.arsize !== 3'b010 || bus.awsize !== 3'b010) begin
            n_fail++; $display("FAIL reset_size got %b/%b exp 010", bus.arsize, bus.awsize);
        end
        tick;
        m_aresetn = 1'b1;
        tick;
    endtask

    task automatic test_single_read;
        int c1;
        c1 = rsp1_cnt;
        s_rdata = 32'hA5; s_rresp = 2'b00;
        req0_valid = 1; req0_write = 0; req0_addr = 32'h10;
        mid;
        n_chk++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_fail++; $display("FAIL rd_accept got %b exp 10", {req0_ready, req1_ready});
        end
        tick; req0_valid = 0; mid;
        n_chk++;
        if (bus.arvalid !== 1'b1 || bus.araddr !== 32'h10) begin
            n_fail++; $display("FAIL rd_ar got %b %h exp 1 00000010", bus.arvalid, bus.araddr);
        end
        tick; mid;
        n_chk++;
        if (bus.rready !== 1'b1) begin
            n_fail++; $display("FAIL rd_rready got %b exp 1", bus.rready);
        end
        tick; mid;
        n_chk++;
        if (rsp0_valid !== 1'b1 || rsp0_rdata !== 32'hA5 || rsp0_resp !== 2'b00) begin
            n_fail++;
            $display("FAIL rd_rsp got %b %h %b exp 1 000000a5 00", rsp0_valid, rsp0_rdata, rsp0_resp);
        end
        tick; mid;
        n_chk++;
        if (busy !== 1'b0 || last_grant !== 1'b0) begin
            n_fail++; $display("FAIL rd_done got busy %b lg %b exp 0 0", busy, last_grant);
        end
        n_chk++;
        if (rsp1_cnt !== c1) begin
            n_fail++; $display("FAIL rd_rsp1_quiet got %0d pulses exp 0", rsp1_cnt - c1);
        end
        tick;
    endtask

    task automatic test_skewed_write;
        aw_dly = 2; w_dly = 0; b_dly = 0; s_bresp = 2'b10;
        req1_valid = 1; req1_write = 1; req1_addr = 32'h20;
        req1_wdata = 32'h3C; req1_wstrb = 4'b0001;
        mid;
        n_chk++;
        if (req1_ready !== 1'b1) begin
            n_fail++; $display("FAIL wr_accept got %b exp 1", req1_ready);
        end
        tick; req1_valid = 0; mid;
        n_chk++;
        if ({bus.awvalid, bus.wvalid} !== 2'b11 || bus.awaddr !== 32'h20 ||
            bus.wdata !== 32'h3C || bus.wstrb !== 4'b0001) begin
            n_fail++;
            $display("FAIL wr_bus got %b %h %h %b exp 11 00000020 0000003c 0001",
                {bus.awvalid, bus.wvalid}, bus.awaddr, bus.wdata, bus.wstrb);
        end
        tick; mid;
        n_chk++;
        if ({bus.awvalid, bus.wvalid, bus.bready} !== 3'b100) begin
            n_fail++; $display("FAIL wr_wdrop got %b exp 100", {bus.awvalid, bus.wvalid, bus.bready});
        end
        tick; mid;
        n_chk++;
        if ({bus.awvalid, bus.wvalid, bus.bready} !== 3'b100) begin
            n_fail++; $display("FAIL wr_awwait got %b exp 100", {bus.awvalid, bus.wvalid, bus.bready});
        end
        tick; mid;
        n_chk++;
        if ({bus.awvalid, bus.wvalid, bus.bready} !== 3'b001) begin
            n_fail++; $display("FAIL wr_b got %b exp 001", {bus.awvalid, bus.wvalid, bus.bready});
        end
        tick; mid;
        n_chk++;
        if ({rsp1_valid, rsp0_valid} !== 2'b10 || rsp1_resp !== 2'b10 || rsp1_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL wr_rsp got %b %b %h exp 10 10 00000000",
                {rsp1_valid, rsp0_valid}, rsp1_resp, rsp1_rdata);
        end
        tick; mid;
        n_chk++;
        if (last_grant !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL wr_done got lg %b busy %b exp 1 0", last_grant, busy);
        end
        aw_dly = 0; s_bresp = 2'b00;
        tick;
    endtask

    task automatic test_contention;
        logic e;
        m_aresetn = 0;
        tick;
        m_aresetn = 1;
        s_rdata = 32'h5A; s_rresp = 2'b00;
        req0_valid = 1; req0_write = 0; req0_addr = 32'h100;
        req1_valid = 1; req1_write = 0; req1_addr = 32'h200;
        mid;
        for (int k = 0; k < 4; k++) begin
            e = (k % 2) != 0;
            n_chk++;
            if ({req1_ready, req0_ready} !== (e ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL cont_grant%0d got %b exp %b", k, {req1_ready, req0_ready},
                    e ? 2'b10 : 2'b01);
            end
            tick; tick; tick; mid;
            n_chk++;
            if ({rsp1_valid, rsp0_valid} !== (e ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL cont_rsp%0d got %b exp %b", k, {rsp1_valid, rsp0_valid},
                    e ? 2'b10 : 2'b01);
            end
            tick;
            if (k == 3) begin
                req0_valid = 0; req1_valid = 0;
            end
            mid;
            n_chk++;
            if (last_grant !== e) begin
                n_fail++; $display("FAIL cont_last_grant%0d got %b exp %b", k, last_grant, e);
            end
        end
        tick;
    endtask

    task automatic test_back_to_back;
        int acc [3];
        int n_acc;
        acc = '{0, 0, 0};
        n_acc = 0;
        req0_valid = 1; req0_write = 0; req0_addr = 32'h300;
        for (int i = 0; i < 20 && n_acc < 3; i++) begin
            mid;
            if (req0_ready === 1'b1) begin
                acc[n_acc] = cyc; n_acc++;
            end
            tick;
        end
        req0_valid = 0;
        n_chk++;
        if (n_acc !== 3) begin
            n_fail++; $display("FAIL b2b_count got %0d exp 3", n_acc);
        end
        n_chk++;
        if (acc[1] - acc[0] !== 4 || acc[2] - acc[1] !== 4) begin
            n_fail++;
            $display("FAIL b2b_spacing got %0d %0d exp 4 4", acc[1] - acc[0], acc[2] - acc[1]);
        end
        repeat (3) tick;
    endtask

    task automatic test_slow_read;
        ar_dly = 5; r_dly = 3;
        s_rdata = 32'hDEADBEEF; s_rresp = 2'b01;
        req0_valid = 1; req0_write = 0; req0_addr = 32'h40;
        req1_write = 0; req1_addr = 32'h50;
        mid;
        n_chk++;
        if (req0_ready !== 1'b1) begin
            n_fail++; $display("FAIL slow_accept got %b exp 1", req0_ready);
        end
        tick; req0_valid = 0; req1_valid = 1;
        for (int i = 0; i < 6; i++) begin
            mid;
            n_chk++;
            if ({bus.arvalid, busy, req1_ready} !== 3'b110 || bus.araddr !== 32'h40) begin
                n_fail++;
                $display("FAIL slow_ar%0d got %b %h exp 110 00000040", i,
                    {bus.arvalid, busy, req1_ready}, bus.araddr);
            end
            tick;
        end
        for (int i = 0; i < 4; i++) begin
            mid;
            n_chk++;
            if ({bus.rready, busy, req1_ready, bus.arvalid} !== 4'b1100) begin
                n_fail++;
                $display("FAIL slow_r%0d got %b exp 1100", i,
                    {bus.rready, busy, req1_ready, bus.arvalid});
            end
            tick;
        end
        mid;
        n_chk++;
        if (rsp0_valid !== 1'b1 || rsp0_rdata !== 32'hDEADBEEF || rsp0_resp !== 2'b01) begin
            n_fail++;
            $display("FAIL slow_rsp got %b %h %b exp 1 deadbeef 01", rsp0_valid, rsp0_rdata, rsp0_resp);
        end
        ar_dly = 0; r_dly = 0;
        tick; mid;
        n_chk++;
        if (req1_ready !== 1'b1) begin
            n_fail++; $display("FAIL slow_req1_accept got %b exp 1", req1_ready);
        end
        tick; req1_valid = 0;
        tick; tick; mid;
        n_chk++;
        if (rsp1_valid !== 1'b1 || rsp1_rdata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL slow_rsp1 got %b %h exp 1 deadbeef", rsp1_valid, rsp1_rdata);
        end
        tick;
    endtask

    task automatic test_reset_mid;
        int c0;
        r_dly = 10; s_rresp = 2'b00;
        req0_valid = 1; req0_write = 0; req0_addr = 32'h60;
        mid;
        n_chk++;
        if (req0_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_accept got %b exp 1", req0_ready);
        end
        tick; req0_valid = 0;
        tick;
        c0 = rsp0_cnt;
        #1;
        n_chk++;
        if (bus.rready !== 1'b1) begin
            n_fail++; $display("FAIL rst_in_r got %b exp 1", bus.rready);
        end
        m_aresetn = 0;
        #1;
        n_chk++;
        if ({bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready,
             busy, rsp0_valid, rsp1_valid} !== 8'h0) begin
            n_fail++;
            $display("FAIL rst_async got %b exp 00000000", {bus.arvalid, bus.rready,
                bus.awvalid, bus.wvalid, bus.bready, busy, rsp0_valid, rsp1_valid});
        end
        tick; tick;
        m_aresetn = 1;
        r_dly = 0; s_rdata = 32'h12345678;
        repeat (12) tick;
        mid;
        n_chk++;
        if (rsp0_cnt !== c0 || last_grant !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_no_rsp got %0d pulses lg %b exp 0 pulses lg 1", rsp0_cnt - c0, last_grant);
        end
        tick;
        req0_valid = 1; req0_addr = 32'h70;
        mid;
        n_chk++;
        if (req0_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_reaccept got %b exp 1", req0_ready);
        end
        tick; req0_valid = 0;
        tick; tick; mid;
        n_chk++;
        if (rsp0_valid !== 1'b1 || rsp0_rdata !== 32'h12345678) begin
            n_fail++; $display("FAIL rst_after_rsp got %b %h exp 1 12345678", rsp0_valid, rsp0_rdata);
        end
        tick;
    endtask

    initial begin
        m_aresetn = 0;
        req0_valid = 0; req0_write = 0; req0_addr = 0; req0_wdata = 0; req0_wstrb = 0;
        req1_valid = 0; req1_write = 0; req1_addr = 0; req1_wdata = 0; req1_wstrb = 0;
        ar_dly = 0; r_dly = 0; aw_dly = 0; w_dly = 0; b_dly = 0;
        s_rdata = 0; s_rresp = 0; s_bresp = 0;
        test_reset;
        test_single_read;
        test_skewed_write;
        test_contention;
        test_back_to_back;
        test_slow_read;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uartprobe_axi_arbiter.md
# uartprobe_axi_arbiter

Two-requester arbiter and sequencer for the probe's single AXI master port. It lets the UART probe's command engine and a second on-chip requester (e.g. a scripted boot loader) share one AXI4-lite-style master. It accepts one single-beat read or write at a time, drives the AR/R or AW/W/B handshakes to completion, and returns the response to the owning requester. It sits between the requesters and the `m_axi_*` fabric port.

## Interface
- `PRIORITY_INIT`, default 0: requester that wins the first contended arbitration after reset.
- `AXI_SIZE`, default 3'b010: constant value driven on `m_axi_arsize` and `m_axi_awsize`.

- `clk`  in  1  clock.
- `m_aresetn`  in  1  reset, asynchronous, active-low.
- `reqN_valid`  in  1  request from requester N (N = 0, 1); held stable until accepted.
- `reqN_ready`  out  1  request N accepted this cycle.
- `reqN_write`  in  1  1 = write, 0 = read.
- `reqN_addr`  in  32  byte address.
- `reqN_wdata`  in  32  write data.
- `reqN_wstrb`  in  4  write strobes.
- `rspN_valid`  out  1  one-cycle response pulse to requester N; no backpressure.
- `rspN_rdata`  out  32  read data; 0 for writes.
- `rspN_resp`  out  2  rresp/bresp, passed through unmodified.
- `busy`  out  1  FSM not in IDLE.
- `last_grant`  out  1  index of the most recently served requester.
- `m_axi_araddr`/`arvalid`/`arsize` (out 32/1/3), `m_axi_arready` (in 1): read address channel.
- `m_axi_rdata`/`rresp`/`rvalid` (in 32/2/1), `m_axi_rready` (out 1): read data channel.
- `m_axi_awaddr`/`awvalid`/`awsize` (out 32/1/3), `m_axi_awready` (in 1): write address channel.
- `m_axi_wdata`/`wstrb`/`wvalid` (out 32/4/1), `m_axi_wready` (in 1): write data channel.
- `m_axi_bresp`/`bvalid` (in 2/1), `m_axi_bready` (out 1): write response channel.

## Operation
- **States:** IDLE, AR, R, AWW, B, RSP.
- **IDLE arbitration**
  - With one requester valid, that requester is granted.
  - With both valid, the requester not equal to `last_grant` is granted.
  - `reqN_ready` is combinational: IDLE and grant = N.
  - On acceptance, latch write, addr, wdata, wstrb and owner.
  - Next state is AWW for a write, AR for a read.
- **AR:** `arvalid`=1 and `araddr` = latched address. On `arready` go to R.
- **R:** `rready`=1. On `rvalid`, latch `rdata` and `rresp`, then go to RSP.
- **AWW**
  - Assert `awvalid` and `wvalid` together.
  - Each valid drops independently after its own handshake; track this with `aw_done` and `w_done` flags.
  - Go to B in the cycle when both handshakes have completed, including the case where both complete in the same cycle.
- **B:** `bready`=1. On `bvalid`, latch `bresp`, set rdata to 0, then go to RSP.
- **RSP**
  - `rspN_valid`=1 for the owner only, for exactly one cycle.
  - Update `last_grant` to the owner, then go to IDLE.
- **Non-IDLE states:** both `reqN_ready` are 0. A pending requester keeps its valid asserted and waits.
- **Uncontended requests:** a single requester issuing repeatedly is served every time. Round-robin order applies only under contention.
- **Stray channel inputs:** `rvalid`/`bvalid` outside R/B are ignored, because the matching ready is 0.
- **Reset values:**
  - All `m_axi_*valid`, `rready`, `bready`, `reqN_ready`, `rspN_valid` and `busy` are 0.
  - Addresses, data and resp outputs are 0.
  - `last_grant` = ~`PRIORITY_INIT`.
  - State is IDLE.
- **Reset mid-transaction:** return to IDLE immediately. No response is issued, and the interrupted request is dropped.

## Timing
- **Accept to bus:** request accepted in cycle T, so `arvalid`/`awvalid`/`wvalid` are first high at T+1.
- **Read with zero-wait slave:**
  - `arready` at T+1.
  - `rready` and `rvalid` at T+2.
  - `rsp_valid` at T+3.
  - Next acceptance possible at T+4.
- **Write with zero-wait slave:**
  - `awready`/`wready` at T+1.
  - B at T+2 with `bvalid`.
  - `rsp_valid` at T+3.
- **Throughput:** peak one transaction per 4 cycles.
- **Handshake completion:** every handshake completes on a cycle where valid and ready are both high. Valid never drops before its ready is seen.

## Test plan
- **Single read:** `req0` read addr 0x0000_0010, slave returns 0xA5 with OKAY. Expect `araddr`=0x10 at T+1, `rsp0_valid` at T+3 with rdata 0xA5 and resp 0, and `rsp1_valid` never asserted.
- **Write with skewed handshakes:** `req1` write addr 0x20, data 0x3C, strb 4'b0001. `wready` comes 2 cycles before `awready`. Expect `wvalid` to drop after its handshake, B entered only after `awready`, and `bresp`=2'b10 returned on `rsp1_resp`.
- **Contention:** both requesters valid continuously for 4 transactions with `PRIORITY_INIT`=0. Expect grants in order 0,1,0,1 and `last_grant` toggling after each RSP.
- **Back-to-back uncontended:** `req0` issues 3 back-to-back reads to a zero-wait slave. Expect acceptances at T, T+4, T+8.
- **Slow read slave:** `arready` delayed 5 cycles and `rvalid` delayed 3 cycles. Expect `arvalid` held stable and `busy`=1 throughout, with `req1_ready` staying 0 while `req1_valid`=1.
- **Reset mid-transaction:** assert `m_aresetn` low while in R. Expect all valids to be 0 asynchronously, no `rsp` pulse, and the next request after release accepted normally.
